// File: rtl/gram_access_sched_pkg.sv
// Shared constants for the GRAM side-port scheduler: board geometry, bus
// widths, FSM encoding, arbiter grant codes and tile codes.
package gram_pkg;

   localparam int unsigned BOARD_W = 20;
   localparam int unsigned BOARD_H = 15;
   localparam int unsigned CELLS   = BOARD_W * BOARD_H;
   localparam int unsigned AW      = 9;
   localparam int unsigned DW      = 4;

   localparam logic [AW-1:0] CELLS_A   = 9'd300;
   localparam logic [AW-1:0] LAST_CELL = 9'd299;

   // FSM encoding kept as plain constants so older tools can read it
   localparam logic [2:0] ST_IDLE = 3'd0;
   localparam logic [2:0] ST_GWR  = 3'd1;
   localparam logic [2:0] ST_GRD0 = 3'd2;
   localparam logic [2:0] ST_GRD1 = 3'd3;
   localparam logic [2:0] ST_CLR  = 3'd4;

   typedef enum logic [1:0] {
      GNT_NONE = 2'd0,
      GNT_CLR  = 2'd1,
      GNT_GM   = 2'd2,
      GNT_LD   = 2'd3
   } grant_t;

   localparam logic [DW-1:0] TILE_FLOOR  = 4'h0;
   localparam logic [DW-1:0] TILE_WALL   = 4'h1;
   localparam logic [DW-1:0] TILE_BOX    = 4'h2;
   localparam logic [DW-1:0] TILE_GOAL   = 4'h3;
   localparam logic [DW-1:0] TILE_PLAYER = 4'h4;

   // True when the address names a real board tile
   function automatic logic in_range(input logic [AW-1:0] addr);
      return (addr < CELLS_A);
   endfunction

endpackage

// File: rtl/gram_access_sched_if.sv
// Requester and GRAM side-port signals of the scheduler, bundled so the
// scheduler sees one port; slave is the scheduler view, master the peers.
interface gram_access_sched_if;

   logic                      clr_req;
   logic [gram_pkg::DW-1:0]   clr_val;
   logic                      clr_busy;
   logic                      gm_req;
   logic                      gm_we;
   logic [gram_pkg::AW-1:0]   gm_addr;
   logic [gram_pkg::DW-1:0]   gm_wdata;
   logic                      gm_ack;
   logic [gram_pkg::DW-1:0]   gm_rdata;
   logic                      gm_err;
   logic                      ld_valid;
   logic [gram_pkg::AW-1:0]   ld_addr;
   logic [gram_pkg::DW-1:0]   ld_data;
   logic                      ld_ready;
   logic                      Gwea;
   logic                      Grea;
   logic [gram_pkg::AW-1:0]   GAddr_w;
   logic [gram_pkg::DW-1:0]   GData_in;
   logic [gram_pkg::DW-1:0]   GData_out;

   modport slave (
      input  clr_req, clr_val, gm_req, gm_we, gm_addr, gm_wdata,
             ld_valid, ld_addr, ld_data, GData_out,
      output clr_busy, gm_ack, gm_rdata, gm_err, ld_ready,
             Gwea, Grea, GAddr_w, GData_in
   );

   modport master (
      output clr_req, clr_val, gm_req, gm_we, gm_addr, gm_wdata,
             ld_valid, ld_addr, ld_data, GData_out,
      input  clr_busy, gm_ack, gm_rdata, gm_err, ld_ready,
             Gwea, Grea, GAddr_w, GData_in
   );

endinterface

// File: rtl/gram_access_sched_prio_arb.sv
// Three-way fixed-priority arbiter (clear > game > loader) where a pending
// loader word overtakes the game once a game access has completed since the
// loader was last served, so neither game nor loader can starve the other.
module gram_prio_arb
   import gram_pkg::*;
(
   input  logic   en,
   input  logic   clr_req,
   input  logic   gm_req,
   input  logic   ld_valid,
   input  logic   turn,
   output grant_t grant
);

   // Pick the winning requester for this cycle
   always_comb begin
      grant = GNT_NONE;
      if (!en) begin
         grant = GNT_NONE;
      end else if (clr_req) begin
         grant = GNT_CLR;
      end else if (turn && ld_valid) begin
         grant = GNT_LD;
      end else if (gm_req) begin
         grant = GNT_GM;
      end else if (ld_valid) begin
         grant = GNT_LD;
      end else begin
         grant = GNT_NONE;
      end
   end

endmodule

// File: rtl/gram_access_sched.sv
// Sole owner of the GRAM side-port: arbitrates board clear, game single-cell
// accesses and the level loader, sequences the one-cycle read latency and
// range-checks addresses against the 20x15 board. One access in flight.
module gram_access_sched
   import gram_pkg::*;
(
   input  logic               clk,
   input  logic               rst_n,
   gram_access_sched_if.slave bus
);

   logic [2:0]    state;
   logic [AW-1:0] cnt;
   logic          turn;
   logic          ld_wr;
   logic [DW-1:0] rdata_hold;
   logic          gwea;
   logic          grea;
   logic [AW-1:0] gaddr;
   logic [DW-1:0] gdin;
   logic          ack;
   logic          err;
   logic          busy;
   logic          arb_en;
   grant_t        grant;

   // Arbitration only while idle and not in the loader write's holdoff cycle
   assign arb_en = (state == ST_IDLE) && !ld_wr;

   gram_prio_arb u_arb (
      .en       (arb_en),
      .clr_req  (bus.clr_req),
      .gm_req   (bus.gm_req),
      .ld_valid (bus.ld_valid),
      .turn     (turn),
      .grant    (grant)
   );

   assign bus.ld_ready = arb_en && (grant == GNT_LD);
   assign bus.Gwea     = gwea;
   assign bus.Grea     = grea;
   assign bus.GAddr_w  = gaddr;
   assign bus.GData_in = gdin;
   assign bus.gm_ack   = ack;
   assign bus.gm_err   = err;
   assign bus.clr_busy = busy;
   // RAM data lands in GRD1 together with the ack, so pass it through then
   assign bus.gm_rdata = (state == ST_GRD1) ? bus.GData_out : rdata_hold;

   // Scheduler FSM, fill counter and registered GRAM port
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         cnt        <= {AW{1'b0}};
         turn       <= 1'b0;
         ld_wr      <= 1'b0;
         rdata_hold <= {DW{1'b0}};
         gwea       <= 1'b0;
         grea       <= 1'b0;
         gaddr      <= {AW{1'b0}};
         gdin       <= {DW{1'b0}};
         ack        <= 1'b0;
         err        <= 1'b0;
         busy       <= 1'b0;
      end else begin
         ack   <= 1'b0;
         err   <= 1'b0;
         ld_wr <= 1'b0;
         case (state)
            ST_IDLE: begin
               gwea <= 1'b0;
               grea <= 1'b0;
               case (grant)
                  GNT_CLR: begin
                     state <= ST_CLR;
                     gwea  <= 1'b1;
                     gaddr <= {AW{1'b0}};
                     gdin  <= bus.clr_val;
                     cnt   <= {AW{1'b0}};
                     busy  <= 1'b1;
                  end
                  GNT_GM: begin
                     turn <= 1'b1;
                     if (!in_range(bus.gm_addr)) begin
                        state <= ST_GWR;
                        ack   <= 1'b1;
                        err   <= 1'b1;
                     end else if (bus.gm_we) begin
                        state <= ST_GWR;
                        gwea  <= 1'b1;
                        gaddr <= bus.gm_addr;
                        gdin  <= bus.gm_wdata;
                        ack   <= 1'b1;
                     end else begin
                        state <= ST_GRD0;
                        grea  <= 1'b1;
                        gaddr <= bus.gm_addr;
                     end
                  end
                  GNT_LD: begin
                     ld_wr <= 1'b1;
                     turn  <= 1'b0;
                     gwea  <= in_range(bus.ld_addr);
                     gaddr <= bus.ld_addr;
                     gdin  <= bus.ld_data;
                  end
                  default: begin
                     state <= ST_IDLE;
                  end
               endcase
            end
            ST_GWR: begin
               gwea  <= 1'b0;
               state <= ST_IDLE;
            end
            ST_GRD0: begin
               grea  <= 1'b1;
               ack   <= 1'b1;
               state <= ST_GRD1;
            end
            ST_GRD1: begin
               grea       <= 1'b0;
               rdata_hold <= bus.GData_out;
               state      <= ST_IDLE;
            end
            ST_CLR: begin
               if (cnt == LAST_CELL) begin
                  gwea  <= 1'b0;
                  busy  <= 1'b0;
                  cnt   <= {AW{1'b0}};
                  state <= ST_IDLE;
               end else begin
                  gwea  <= 1'b1;
                  cnt   <= cnt + 9'd1;
                  gaddr <= cnt + 9'd1;
               end
            end
            default: begin
               gwea  <= 1'b0;
               grea  <= 1'b0;
               busy  <= 1'b0;
               cnt   <= {AW{1'b0}};
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_gram_access_sched.sv
// Bench for gram_access_sched: behavioural GRAM, reference board image and a
// scoreboard of expected game responses pushed at request, popped at gm_ack.
module tb_gram_access_sched;
   import gram_pkg::*;

   typedef struct packed {
      logic          err;
      logic [DW-1:0] rdata;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   gram_access_sched_if bus();

   gram_access_sched dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   always #5 clk = ~clk;

   logic [DW-1:0] mem [0:511];
   logic [DW-1:0] ram_q = 4'h0;
   logic [DW-1:0] ref_board [0:299];
   logic [DW-1:0] exp_hold;
   exp_t sb[$];
   int vectors = 0;
   int miscompares = 0;

   // GRAM model: synchronous write, one-cycle read latency
   always @(posedge clk) begin
      if (bus.Gwea === 1'b1) mem[bus.GAddr_w] <= bus.GData_in;
      if (bus.Grea === 1'b1) ram_q <= mem[bus.GAddr_w];
   end
   assign bus.GData_out = ram_q;

   // Write and read enables must never be high together
   always @(negedge clk) begin
      if (rst_n) begin
         vectors++;
         if (bus.Gwea === 1'b1 && bus.Grea === 1'b1) begin
            miscompares++;
            $display("FAIL we_re_exclusive: Gwea=%b Grea=%b required not both 1", bus.Gwea, bus.Grea);
         end
      end
   end

   task automatic game_access(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                              input int exp_lat, input string name);
      exp_t e;
      exp_t got;
      int lat;
      logic seen;
      logic grea_seen;
      logic [AW-1:0] lim;
      lim = 9'd300;
      e.err = (addr >= lim);
      if (!e.err && we) ref_board[addr] = wdata;
      if (!e.err && !we) exp_hold = ref_board[addr];
      e.rdata = exp_hold;
      sb.push_back(e);
      @(negedge clk);
      bus.gm_req = 1'b1; bus.gm_we = we; bus.gm_addr = addr; bus.gm_wdata = wdata;
      lat = 0; seen = 1'b0; grea_seen = 1'b0;
      while (!seen && lat < 500) begin
         @(negedge clk);
         lat++;
         if (bus.Grea === 1'b1) grea_seen = 1'b1;
         if (bus.gm_ack === 1'b1) seen = 1'b1;
      end
      vectors++;
      if (!seen) begin
         miscompares++;
         $display("FAIL %s_timeout: no gm_ack after %0d cycles", name, lat);
         void'(sb.pop_front());
      end else begin
         e = sb.pop_front();
         got.err = bus.gm_err; got.rdata = bus.gm_rdata;
         vectors++;
         if (got !== e) begin
            miscompares++;
            $display("FAIL %s_resp: err/rdata=%b/%h required %b/%h", name, got.err, got.rdata, e.err, e.rdata);
         end
         if (exp_lat > 0) begin
            vectors++;
            if (lat !== exp_lat) begin
               miscompares++;
               $display("FAIL %s_latency: ack after %0d cycles required %0d", name, lat, exp_lat);
            end
         end
         if (we && !e.err) begin
            vectors++;
            if ({bus.Gwea, bus.GAddr_w, bus.GData_in} !== {1'b1, addr, wdata}) begin
               miscompares++;
               $display("FAIL %s_wport: we/addr/data=%b/%0d/%h required 1/%0d/%h", name,
                        bus.Gwea, bus.GAddr_w, bus.GData_in, addr, wdata);
            end
         end
         if (e.err) begin
            vectors++;
            if (grea_seen !== 1'b0) begin
               miscompares++;
               $display("FAIL %s_no_read: Grea seen=%b required 0", name, grea_seen);
            end
         end
      end
      bus.gm_req = 1'b0;
   endtask

   task automatic load_word(input logic [AW-1:0] addr, input logic [DW-1:0] data, input string name);
      int n;
      logic ok;
      logic [AW-1:0] lim;
      lim = 9'd300;
      ok = (addr < lim);
      @(negedge clk);
      bus.ld_valid = 1'b1; bus.ld_addr = addr; bus.ld_data = data;
      n = 0;
      #1;
      while (bus.ld_ready !== 1'b1 && n < 50) begin
         @(negedge clk); #1; n++;
      end
      vectors++;
      if (bus.ld_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL %s_timeout: ld_ready not seen in %0d cycles", name, n);
      end else begin
         @(negedge clk);
         vectors++;
         if (ok) begin
            ref_board[addr] = data;
            if ({bus.Gwea, bus.GAddr_w, bus.GData_in} !== {1'b1, addr, data}) begin
               miscompares++;
               $display("FAIL %s_wport: we/addr/data=%b/%0d/%h required 1/%0d/%h", name,
                        bus.Gwea, bus.GAddr_w, bus.GData_in, addr, data);
            end
         end else if (bus.Gwea !== 1'b0) begin
            miscompares++;
            $display("FAIL %s_drop: Gwea=%b required 0", name, bus.Gwea);
         end
         vectors++;
         if (bus.ld_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL %s_holdoff: ld_ready=%b required 0", name, bus.ld_ready);
         end
      end
      bus.ld_valid = 1'b0;
   endtask

   task automatic test_reset();
      bus.clr_req = 1'b0; bus.clr_val = 4'h0;
      bus.gm_req = 1'b0; bus.gm_we = 1'b0; bus.gm_addr = 9'd0; bus.gm_wdata = 4'h0;
      bus.ld_valid = 1'b0; bus.ld_addr = 9'd0; bus.ld_data = 4'h0;
      exp_hold = 4'h0;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         vectors++;
         if ({bus.Gwea, bus.Grea, bus.gm_ack, bus.gm_err, bus.clr_busy, bus.ld_ready,
              bus.GAddr_w, bus.GData_in, bus.gm_rdata} !== 23'd0) begin
            miscompares++;
            $display("FAIL reset_idle: cycle %0d we=%b re=%b ack=%b err=%b busy=%b rdy=%b addr=%0d din=%h rd=%h required all 0",
                     i, bus.Gwea, bus.Grea, bus.gm_ack, bus.gm_err, bus.clr_busy, bus.ld_ready,
                     bus.GAddr_w, bus.GData_in, bus.gm_rdata);
         end
      end
   endtask

   task automatic test_game_rw();
      game_access(1'b1, 9'd45, 4'h3, 1, "gm_wr45");
      game_access(1'b0, 9'd45, 4'h0, 2, "gm_rd45");
      game_access(1'b1, 9'd46, 4'hA, 1, "gm_wr46");
      game_access(1'b0, 9'd46, 4'h0, 2, "gm_rd46");
   endtask

   task automatic test_out_of_range();
      game_access(1'b0, 9'd300, 4'h0, 1, "gm_rd300");
      game_access(1'b1, 9'd511, 4'h7, 1, "gm_wr511");
      game_access(1'b0, 9'd299, 4'h0, 2, "gm_rd299");
   endtask

   task automatic test_clear(input logic [DW-1:0] val);
      int wr_cnt;
      int busy_cnt;
      int bad;
      logic seen;
      logic ack_busy;
      logic [AW-1:0] nxt;
      exp_t e;
      exp_t got;
      wr_cnt = 0; busy_cnt = 0; bad = 0; seen = 1'b0; ack_busy = 1'b0; nxt = 9'd0;
      e.err = 1'b0; e.rdata = val;
      sb.push_back(e);
      @(negedge clk);
      bus.clr_req = 1'b1; bus.clr_val = val;
      bus.gm_req = 1'b1; bus.gm_we = 1'b0; bus.gm_addr = 9'd45;
      @(negedge clk);
      bus.clr_req = 1'b0;
      for (int i = 0; i < 700 && !seen; i++) begin
         if (bus.Gwea === 1'b1) begin
            if (bus.GAddr_w !== nxt || bus.GData_in !== val) bad++;
            nxt = nxt + 9'd1;
            wr_cnt++;
         end
         if (bus.clr_busy === 1'b1) busy_cnt++;
         if (bus.gm_ack === 1'b1) begin
            seen = 1'b1;
            if (bus.clr_busy === 1'b1) ack_busy = 1'b1;
         end else begin
            @(negedge clk);
         end
      end
      vectors++;
      if (!seen) begin
         miscompares++;
         $display("FAIL clr_pending_ack: no gm_ack after clear");
         void'(sb.pop_front());
      end else begin
         e = sb.pop_front();
         got.err = bus.gm_err; got.rdata = bus.gm_rdata;
         vectors++;
         if (got !== e) begin
            miscompares++;
            $display("FAIL clr_pending_resp: err/rdata=%b/%h required %b/%h", got.err, got.rdata, e.err, e.rdata);
         end
      end
      bus.gm_req = 1'b0;
      vectors++;
      if (wr_cnt !== 300) begin
         miscompares++;
         $display("FAIL clr_writes: %0d Gwea cycles required 300", wr_cnt);
      end
      vectors++;
      if (busy_cnt !== 300) begin
         miscompares++;
         $display("FAIL clr_busy_len: %0d cycles required 300", busy_cnt);
      end
      vectors++;
      if (bad !== 0) begin
         miscompares++;
         $display("FAIL clr_addr_seq: %0d out-of-sequence writes required 0", bad);
      end
      vectors++;
      if (ack_busy !== 1'b0) begin
         miscompares++;
         $display("FAIL clr_stall: gm_ack during clr_busy=%b required 0", ack_busy);
      end
      for (int a = 0; a < 300; a++) ref_board[a] = val;
      exp_hold = val;
   endtask

   task automatic test_loader();
      load_word(9'd0, TILE_BOX, "ld_0");
      load_word(9'd299, TILE_PLAYER, "ld_299");
      load_word(9'd400, 4'h7, "ld_400");
      load_word(9'd1, TILE_GOAL, "ld_1");
      game_access(1'b0, 9'd0, 4'h0, 2, "ld_rb0");
      game_access(1'b0, 9'd299, 4'h0, 2, "ld_rb299");
      game_access(1'b0, 9'd1, 4'h0, 2, "ld_rb1");
   endtask

   task automatic test_back_to_back();
      int gcnt;
      int lcnt;
      int last;
      int ev;
      int cyc;
      logic r;
      logic a;
      logic adv_ld;
      gcnt = 0; lcnt = 0; last = -1; cyc = 0; adv_ld = 1'b0; r = 1'b0;
      @(negedge clk);
      bus.gm_req = 1'b1; bus.gm_we = 1'b1; bus.gm_addr = 9'd100; bus.gm_wdata = 4'h6;
      bus.ld_valid = 1'b1; bus.ld_addr = 9'd200; bus.ld_data = 4'h9;
      while ((cyc < 100 || r) && cyc < 200) begin
         @(negedge clk);
         cyc++;
         r = bus.ld_ready;
         a = bus.gm_ack;
         if (adv_ld) begin
            bus.ld_addr = bus.ld_addr + 9'd1;
            bus.ld_data = DW'(lcnt + 9);
            adv_ld = 1'b0;
         end
         ev = -1;
         if (r === 1'b1) begin
            ref_board[bus.ld_addr] = bus.ld_data;
            lcnt++;
            adv_ld = 1'b1;
            ev = 1;
         end
         if (a === 1'b1) begin
            ref_board[bus.gm_addr] = bus.gm_wdata;
            gcnt++;
            bus.gm_addr = bus.gm_addr + 9'd1;
            bus.gm_wdata = DW'(gcnt + 6);
            ev = 0;
         end
         if (ev >= 0) begin
            if (last >= 0) begin
               vectors++;
               if (ev === last) begin
                  miscompares++;
                  $display("FAIL alt_order: grant %0d repeated (0=game 1=loader) required alternation", ev);
               end
            end
            last = ev;
         end
      end
      bus.gm_req = 1'b0;
      bus.ld_valid = 1'b0;
      repeat (4) begin
         @(negedge clk);
         if (bus.gm_ack === 1'b1) begin
            ref_board[bus.gm_addr] = bus.gm_wdata;
            gcnt++;
         end
      end
      vectors++;
      if (gcnt < 25) begin
         miscompares++;
         $display("FAIL alt_game_count: %0d game grants required >= 25", gcnt);
      end
      vectors++;
      if (lcnt < 25) begin
         miscompares++;
         $display("FAIL alt_loader_count: %0d loader grants required >= 25", lcnt);
      end
      game_access(1'b0, 9'd100, 4'h0, 2, "alt_rb100");
      game_access(1'b0, 9'd200, 4'h0, 2, "alt_rb200");
      game_access(1'b0, 9'd210, 4'h0, 2, "alt_rb210");
   endtask

   task automatic test_reset_mid_read();
      @(negedge clk);
      bus.gm_req = 1'b1; bus.gm_we = 1'b0; bus.gm_addr = 9'd100;
      @(negedge clk);
      vectors++;
      if (bus.Grea !== 1'b1) begin
         miscompares++;
         $display("FAIL rst_rd_grd0: Grea=%b required 1", bus.Grea);
      end
      #2;
      rst_n = 1'b0;
      #1;
      vectors++;
      if ({bus.Grea, bus.gm_ack} !== 2'b00) begin
         miscompares++;
         $display("FAIL rst_rd_abort: Grea/ack=%b%b required 00", bus.Grea, bus.gm_ack);
      end
      bus.gm_req = 1'b0;
      exp_hold = 4'h0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      vectors++;
      if ({bus.Gwea, bus.Grea, bus.gm_ack, bus.clr_busy, bus.gm_rdata} !== 8'd0) begin
         miscompares++;
         $display("FAIL rst_rd_idle: we/re/ack/busy/rd=%b/%b/%b/%b/%h required all 0",
                  bus.Gwea, bus.Grea, bus.gm_ack, bus.clr_busy, bus.gm_rdata);
      end
      game_access(1'b0, 9'd100, 4'h0, 2, "rst_rd_again");
   endtask

   initial begin
      test_reset();
      test_game_rw();
      test_out_of_range();
      test_clear(TILE_FLOOR);
      test_loader();
      test_back_to_back();
      test_clear(TILE_WALL);
      test_reset_mid_read();
      repeat (2) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
